// File: rtl/stream_array_mp_if.sv
// Handshake bundle for stream_array_mp: one write stream, RD_PORTS read-address
// streams with matching read-data streams, plus the clear control and occupancy count.
interface stream_array_mp_if #(
  parameter int DATA_N   = 32,
  parameter int ADDR_N   = 4,
  parameter int RD_PORTS = 2
);
  logic                       clr;
  logic [ADDR_N-1:0]          wr_addr;
  logic [DATA_N-1:0]          wr_data;
  logic                       wr_valid;
  logic                       wr_ready;
  logic [RD_PORTS*ADDR_N-1:0] rd_addr;
  logic [RD_PORTS-1:0]        rd_addr_valid;
  logic [RD_PORTS-1:0]        rd_addr_ready;
  logic [RD_PORTS*DATA_N-1:0] rd_data;
  logic [RD_PORTS-1:0]        rd_written;
  logic [RD_PORTS-1:0]        rd_data_valid;
  logic [RD_PORTS-1:0]        rd_data_ready;
  logic [ADDR_N:0]            written_count;

  modport master (
    output clr, wr_addr, wr_data, wr_valid, rd_addr, rd_addr_valid, rd_data_ready,
    input  wr_ready, rd_addr_ready, rd_data, rd_written, rd_data_valid, written_count
  );

  modport slave (
    input  clr, wr_addr, wr_data, wr_valid, rd_addr, rd_addr_valid, rd_data_ready,
    output wr_ready, rd_addr_ready, rd_data, rd_written, rd_data_valid, written_count
  );
endinterface

// File: rtl/stream_array_mp.sv
// Multi-read-port stream array with per-entry written flags, write-first forwarding
// and an optional blocking mode that holds a read until its entry has been written.
module stream_array_mp #(
  parameter int DATA_N   = 32,
  parameter int ADDR_N   = 4,
  parameter int DEPTH    = 16,
  parameter int RD_PORTS = 2,
  parameter int BLOCKING = 0
) (
  input logic              clk,
  input logic              nrst,
  stream_array_mp_if.slave bus
);
  localparam logic [ADDR_N:0] DEPTH_W = (ADDR_N+1)'(DEPTH);
  localparam logic [ADDR_N:0] ONE_W   = (ADDR_N+1)'(1);

  logic [DATA_N-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  flag;
  logic [ADDR_N:0]   count;

  logic wr_fire;
  logic wr_hit;
  logic wr_new;

  // Writes beyond DEPTH are accepted by the handshake but touch no state.
  assign bus.wr_ready      = !bus.clr;
  assign wr_fire           = bus.wr_valid & !bus.clr;
  assign wr_hit            = wr_fire & ({1'b0, bus.wr_addr} < DEPTH_W);
  assign wr_new            = wr_hit & !flag[bus.wr_addr];
  assign bus.written_count = count;

  // NOTE: the storage array has no reset; the flags alone say which entries hold data.
  always_ff @(posedge clk) begin
    if (wr_hit) mem[bus.wr_addr] <= bus.wr_data;
  end

  // NOTE: all registered state uses <= so every block samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      flag  <= '0;
      count <= '0;
    end else if (bus.clr) begin
      flag  <= '0;
      count <= '0;
    end else if (wr_hit) begin
      flag[bus.wr_addr] <= 1'b1;
      if (wr_new) count <= count + ONE_W;
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    logic [ADDR_N-1:0] addr;
    logic              in_range;
    logic              fwd;
    logic              hit;
    logic              base_ready;
    logic              addr_ready;
    logic              accept;
    logic [DATA_N-1:0] data_q;
    logic              valid_q;
    logic              written_q;

    assign addr       = bus.rd_addr[p*ADDR_N +: ADDR_N];
    assign in_range   = {1'b0, addr} < DEPTH_W;
    assign fwd        = wr_hit & (bus.wr_addr == addr);
    assign hit        = in_range & (flag[addr] | fwd);
    assign base_ready = !valid_q | bus.rd_data_ready[p];
    // Out-of-range addresses bypass the blocking stall so they can never deadlock.
    assign addr_ready = (BLOCKING != 0) ? (base_ready & (hit | !in_range)) : base_ready;
    assign accept     = bus.rd_addr_valid[p] & addr_ready;

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        valid_q   <= 1'b0;
        written_q <= 1'b0;
        data_q    <= '0;
      end else if (accept) begin
        valid_q   <= 1'b1;
        written_q <= hit;
        data_q    <= !hit ? '0 : (fwd ? bus.wr_data : mem[addr]);
      end else if (bus.rd_data_ready[p]) begin
        valid_q   <= 1'b0;
      end
    end

    assign bus.rd_addr_ready[p]               = addr_ready;
    assign bus.rd_data_valid[p]               = valid_q;
    assign bus.rd_written[p]                  = written_q;
    assign bus.rd_data[p*DATA_N +: DATA_N]    = data_q;
  end
endmodule

// File: tb/tb_stream_array_mp.sv
// Directed bench: a non-blocking 16-entry array and a blocking 12-entry array
// exercised side by side, with hand-computed expected results.
module tb_stream_array_mp;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NP = 2;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  stream_array_mp_if #(.DATA_N(DW), .ADDR_N(AW), .RD_PORTS(NP)) bus_nb ();
  stream_array_mp_if #(.DATA_N(DW), .ADDR_N(AW), .RD_PORTS(NP)) bus_b ();

  stream_array_mp #(.DATA_N(DW), .ADDR_N(AW), .DEPTH(16), .RD_PORTS(NP), .BLOCKING(0)) dut_nb (
    .clk(clk), .nrst(nrst), .bus(bus_nb)
  );
  stream_array_mp #(.DATA_N(DW), .ADDR_N(AW), .DEPTH(12), .RD_PORTS(NP), .BLOCKING(1)) dut_b (
    .clk(clk), .nrst(nrst), .bus(bus_b)
  );

  function automatic logic [DW-1:0] nb_data(int p);
    return bus_nb.rd_data[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] b_data(int p);
    return bus_b.rd_data[p*DW +: DW];
  endfunction

  task automatic idle();
    bus_nb.clr = 1'b0; bus_nb.wr_valid = 1'b0; bus_nb.wr_addr = '0; bus_nb.wr_data = '0;
    bus_nb.rd_addr = '0; bus_nb.rd_addr_valid = '0; bus_nb.rd_data_ready = '1;
    bus_b.clr = 1'b0; bus_b.wr_valid = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
    bus_b.rd_addr = '0; bus_b.rd_addr_valid = '0; bus_b.rd_data_ready = '1;
  endtask

  task automatic test_reset();
    idle();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus_nb.rd_data_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid_nb: got %b expected 00", bus_nb.rd_data_valid); end
    n_checks++; if (bus_nb.rd_written !== 2'b00) begin n_fail++; $display("FAIL reset_written_nb: got %b expected 00", bus_nb.rd_written); end
    n_checks++; if (bus_nb.rd_data !== 64'h0) begin n_fail++; $display("FAIL reset_data_nb: got %h expected 0", bus_nb.rd_data); end
    n_checks++; if (bus_nb.written_count !== 5'd0) begin n_fail++; $display("FAIL reset_count_nb: got %0d expected 0", bus_nb.written_count); end
    n_checks++; if (bus_b.rd_data_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid_b: got %b expected 00", bus_b.rd_data_valid); end
    n_checks++; if (bus_nb.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b expected 1", bus_nb.wr_ready); end
    nrst = 1'b1;
  endtask

  task automatic test_empty_read();
    bus_nb.rd_addr[0 +: AW] = 4'd3;
    bus_nb.rd_addr_valid[0] = 1'b1;
    #1;
    n_checks++; if (bus_nb.rd_addr_ready[0] !== 1'b1) begin n_fail++; $display("FAIL empty_addr_ready: got %b expected 1", bus_nb.rd_addr_ready[0]); end
    @(negedge clk);
    bus_nb.rd_addr_valid[0] = 1'b0;
    n_checks++; if (bus_nb.rd_data_valid !== 2'b01) begin n_fail++; $display("FAIL empty_valid: got %b expected 01", bus_nb.rd_data_valid); end
    n_checks++; if (bus_nb.rd_written[0] !== 1'b0) begin n_fail++; $display("FAIL empty_written: got %b expected 0", bus_nb.rd_written[0]); end
    n_checks++; if (nb_data(0) !== 32'h0) begin n_fail++; $display("FAIL empty_data: got %h expected 0", nb_data(0)); end
    n_checks++; if (bus_nb.written_count !== 5'd0) begin n_fail++; $display("FAIL empty_count: got %0d expected 0", bus_nb.written_count); end
    @(negedge clk);
    n_checks++; if (bus_nb.rd_data_valid[0] !== 1'b0) begin n_fail++; $display("FAIL empty_consumed: got %b expected 0", bus_nb.rd_data_valid[0]); end
  endtask

  task automatic test_fill_and_read();
    int i;
    int cyc;
    int issue [NP];
    int got [NP];
    i = 0; cyc = 0;
    while (i < 16 && cyc < 200) begin
      if ($urandom_range(0, 3) == 0) begin
        bus_nb.wr_valid = 1'b0;
      end else begin
        bus_nb.wr_addr  = AW'(i);
        bus_nb.wr_data  = DW'(i + 1);
        bus_nb.wr_valid = 1'b1;
      end
      #1;
      if (bus_nb.wr_valid && bus_nb.wr_ready) i++;
      @(negedge clk);
      cyc++;
    end
    bus_nb.wr_valid = 1'b0;
    n_checks++; if (i !== 16) begin n_fail++; $display("FAIL fill_writes_done: got %0d expected 16", i); end
    n_checks++; if (bus_nb.written_count !== 5'd16) begin n_fail++; $display("FAIL fill_count: got %0d expected 16", bus_nb.written_count); end

    for (int p = 0; p < NP; p++) begin issue[p] = 0; got[p] = 0; end
    cyc = 0;
    while ((got[0] < 16 || got[1] < 16) && cyc < 400) begin
      for (int p = 0; p < NP; p++) begin
        bus_nb.rd_data_ready[p] = 1'($urandom_range(0, 1));
        if (issue[p] < 16) begin
          bus_nb.rd_addr[p*AW +: AW] = AW'(issue[p]);
          bus_nb.rd_addr_valid[p]    = 1'b1;
        end else begin
          bus_nb.rd_addr_valid[p]    = 1'b0;
        end
      end
      #1;
      for (int p = 0; p < NP; p++) begin
        if (bus_nb.rd_data_valid[p] && bus_nb.rd_data_ready[p]) begin
          n_checks++; if (bus_nb.rd_written[p] !== 1'b1) begin n_fail++; $display("FAIL read_written p%0d idx%0d: got %b expected 1", p, got[p], bus_nb.rd_written[p]); end
          n_checks++; if (nb_data(p) !== DW'(got[p] + 1)) begin n_fail++; $display("FAIL read_data p%0d idx%0d: got %0d expected %0d", p, got[p], nb_data(p), got[p] + 1); end
          got[p]++;
        end
        if (bus_nb.rd_addr_valid[p] && bus_nb.rd_addr_ready[p]) issue[p]++;
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (got[0] !== 16 || got[1] !== 16) begin n_fail++; $display("FAIL read_all_done: got %0d/%0d expected 16/16", got[0], got[1]); end
    idle();
    @(negedge clk);
  endtask

  task automatic test_blocking();
    bus_b.rd_addr[AW +: AW] = 4'd5;
    bus_b.rd_addr_valid[1]  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      n_checks++; if (bus_b.rd_addr_ready[1] !== 1'b0) begin n_fail++; $display("FAIL block_stall cyc%0d: got %b expected 0", k, bus_b.rd_addr_ready[1]); end
      @(negedge clk);
    end
    n_checks++; if (bus_b.rd_data_valid[1] !== 1'b0) begin n_fail++; $display("FAIL block_no_result: got %b expected 0", bus_b.rd_data_valid[1]); end
    bus_b.wr_addr = 4'd5; bus_b.wr_data = 32'h2A; bus_b.wr_valid = 1'b1;
    #1;
    n_checks++; if (bus_b.rd_addr_ready[1] !== 1'b1) begin n_fail++; $display("FAIL block_release: got %b expected 1", bus_b.rd_addr_ready[1]); end
    @(negedge clk);
    bus_b.wr_valid = 1'b0; bus_b.rd_addr_valid[1] = 1'b0;
    n_checks++; if (bus_b.rd_data_valid[1] !== 1'b1) begin n_fail++; $display("FAIL block_valid: got %b expected 1", bus_b.rd_data_valid[1]); end
    n_checks++; if (bus_b.rd_written[1] !== 1'b1) begin n_fail++; $display("FAIL block_written: got %b expected 1", bus_b.rd_written[1]); end
    n_checks++; if (b_data(1) !== 32'h2A) begin n_fail++; $display("FAIL block_data: got %h expected 2a", b_data(1)); end
    n_checks++; if (bus_b.written_count !== 5'd1) begin n_fail++; $display("FAIL block_count: got %0d expected 1", bus_b.written_count); end

    // Out-of-range read on the 12-entry instance must not stall.
    bus_b.rd_addr[0 +: AW] = 4'd13; bus_b.rd_addr_valid[0] = 1'b1;
    #1;
    n_checks++; if (bus_b.rd_addr_ready[0] !== 1'b1) begin n_fail++; $display("FAIL oor_ready: got %b expected 1", bus_b.rd_addr_ready[0]); end
    @(negedge clk);
    bus_b.rd_addr_valid[0] = 1'b0;
    n_checks++; if (bus_b.rd_data_valid[0] !== 1'b1) begin n_fail++; $display("FAIL oor_valid: got %b expected 1", bus_b.rd_data_valid[0]); end
    n_checks++; if (bus_b.rd_written[0] !== 1'b0) begin n_fail++; $display("FAIL oor_written: got %b expected 0", bus_b.rd_written[0]); end
    n_checks++; if (b_data(0) !== 32'h0) begin n_fail++; $display("FAIL oor_data: got %h expected 0", b_data(0)); end
    bus_b.wr_addr = 4'd14; bus_b.wr_data = 32'h55; bus_b.wr_valid = 1'b1;
    #1;
    n_checks++; if (bus_b.wr_ready !== 1'b1) begin n_fail++; $display("FAIL oor_wr_ready: got %b expected 1", bus_b.wr_ready); end
    @(negedge clk);
    bus_b.wr_valid = 1'b0;
    n_checks++; if (bus_b.written_count !== 5'd1) begin n_fail++; $display("FAIL oor_wr_count: got %0d expected 1", bus_b.written_count); end
  endtask

  task automatic test_same_cycle();
    bus_b.wr_addr = 4'd2; bus_b.wr_data = 32'd7; bus_b.wr_valid = 1'b1;
    bus_b.rd_addr = {4'd2, 4'd2}; bus_b.rd_addr_valid = 2'b11;
    #1;
    n_checks++; if (bus_b.rd_addr_ready !== 2'b11) begin n_fail++; $display("FAIL fwd_ready: got %b expected 11", bus_b.rd_addr_ready); end
    @(negedge clk);
    bus_b.wr_valid = 1'b0; bus_b.rd_addr_valid = 2'b00;
    n_checks++; if (bus_b.rd_written !== 2'b11) begin n_fail++; $display("FAIL fwd_written: got %b expected 11", bus_b.rd_written); end
    n_checks++; if (b_data(0) !== 32'd7) begin n_fail++; $display("FAIL fwd_data_p0: got %0d expected 7", b_data(0)); end
    n_checks++; if (b_data(1) !== 32'd7) begin n_fail++; $display("FAIL fwd_data_p1: got %0d expected 7", b_data(1)); end
    n_checks++; if (bus_b.written_count !== 5'd2) begin n_fail++; $display("FAIL fwd_count: got %0d expected 2", bus_b.written_count); end
    bus_b.wr_data = 32'd9; bus_b.wr_valid = 1'b1;
    @(negedge clk);
    bus_b.wr_valid = 1'b0;
    n_checks++; if (bus_b.written_count !== 5'd2) begin n_fail++; $display("FAIL rewrite_count: got %0d expected 2", bus_b.written_count); end
    bus_b.rd_addr[0 +: AW] = 4'd2; bus_b.rd_addr_valid[0] = 1'b1;
    @(negedge clk);
    bus_b.rd_addr_valid[0] = 1'b0;
    n_checks++; if (b_data(0) !== 32'd9) begin n_fail++; $display("FAIL rewrite_data: got %0d expected 9", b_data(0)); end
  endtask

  task automatic test_back_pressure();
    bus_nb.rd_data_ready[0] = 1'b0;
    bus_nb.rd_addr[0 +: AW] = 4'd4; bus_nb.rd_addr_valid[0] = 1'b1;
    @(negedge clk);
    n_checks++; if (nb_data(0) !== 32'd5) begin n_fail++; $display("FAIL bp_first: got %0d expected 5", nb_data(0)); end
    bus_nb.rd_addr[0 +: AW] = 4'd6;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (bus_nb.rd_addr_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_stall cyc%0d: got %b expected 0", k, bus_nb.rd_addr_ready[0]); end
      n_checks++; if (nb_data(0) !== 32'd5 || bus_nb.rd_data_valid[0] !== 1'b1) begin n_fail++; $display("FAIL bp_hold cyc%0d: got %0d/%b expected 5/1", k, nb_data(0), bus_nb.rd_data_valid[0]); end
      @(negedge clk);
    end
    bus_nb.rd_data_ready[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      bus_nb.rd_addr[0 +: AW] = AW'(6 + j);
      #1;
      n_checks++; if (bus_nb.rd_addr_ready[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready step%0d: got %b expected 1", j, bus_nb.rd_addr_ready[0]); end
      n_checks++; if (nb_data(0) !== ((j == 0) ? 32'd5 : DW'(6 + j))) begin n_fail++; $display("FAIL b2b_data step%0d: got %0d", j, nb_data(0)); end
      @(negedge clk);
    end
    bus_nb.rd_addr_valid[0] = 1'b0;
    n_checks++; if (nb_data(0) !== 32'd10 || bus_nb.rd_data_valid[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_last: got %0d/%b expected 10/1", nb_data(0), bus_nb.rd_data_valid[0]); end
    @(negedge clk);
  endtask

  task automatic test_clr();
    bus_nb.rd_data_ready[0] = 1'b0;
    bus_nb.rd_addr[0 +: AW] = 4'd3; bus_nb.rd_addr_valid[0] = 1'b1;
    @(negedge clk);
    bus_nb.rd_addr_valid[0] = 1'b0;
    bus_nb.clr = 1'b1;
    bus_nb.wr_addr = 4'd0; bus_nb.wr_data = 32'hFF; bus_nb.wr_valid = 1'b1;
    bus_nb.rd_addr[AW +: AW] = 4'd0; bus_nb.rd_addr_valid[1] = 1'b1;
    #1;
    n_checks++; if (bus_nb.wr_ready !== 1'b0) begin n_fail++; $display("FAIL clr_wr_ready: got %b expected 0", bus_nb.wr_ready); end
    @(negedge clk);
    bus_nb.clr = 1'b0; bus_nb.wr_valid = 1'b0; bus_nb.rd_addr_valid[1] = 1'b0;
    n_checks++; if (bus_nb.written_count !== 5'd0) begin n_fail++; $display("FAIL clr_count: got %0d expected 0", bus_nb.written_count); end
    n_checks++; if (bus_nb.rd_written[1] !== 1'b1 || nb_data(1) !== 32'd1) begin n_fail++; $display("FAIL clr_preclear_read: got %b/%0d expected 1/1", bus_nb.rd_written[1], nb_data(1)); end
    n_checks++; if (bus_nb.rd_data_valid[0] !== 1'b1 || bus_nb.rd_written[0] !== 1'b1 || nb_data(0) !== 32'd4) begin n_fail++; $display("FAIL clr_held_result: got %b/%b/%0d expected 1/1/4", bus_nb.rd_data_valid[0], bus_nb.rd_written[0], nb_data(0)); end
    bus_nb.rd_data_ready[0] = 1'b1;
    bus_nb.rd_addr_valid[1] = 1'b1;
    @(negedge clk);
    bus_nb.rd_addr_valid[1] = 1'b0;
    n_checks++; if (bus_nb.rd_data_valid[1] !== 1'b1 || bus_nb.rd_written[1] !== 1'b0 || nb_data(1) !== 32'd0) begin n_fail++; $display("FAIL clr_postclear_read: got %b/%b/%0d expected 1/0/0", bus_nb.rd_data_valid[1], bus_nb.rd_written[1], nb_data(1)); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus_nb.wr_addr = 4'd5; bus_nb.wr_data = 32'h33; bus_nb.wr_valid = 1'b1;
    bus_nb.rd_data_ready[0] = 1'b0;
    bus_nb.rd_addr[0 +: AW] = 4'd5; bus_nb.rd_addr_valid[0] = 1'b1;
    @(negedge clk);
    bus_nb.wr_valid = 1'b0; bus_nb.rd_addr_valid[0] = 1'b0;
    n_checks++; if (bus_nb.written_count !== 5'd1 || nb_data(0) !== 32'h33) begin n_fail++; $display("FAIL pre_reset: got %0d/%h expected 1/33", bus_nb.written_count, nb_data(0)); end
    #2;
    nrst = 1'b0;
    #1;
    n_checks++; if (bus_nb.rd_data_valid !== 2'b00 || bus_b.rd_data_valid !== 2'b00) begin n_fail++; $display("FAIL async_reset_valid: got %b/%b expected 00/00", bus_nb.rd_data_valid, bus_b.rd_data_valid); end
    n_checks++; if (bus_nb.written_count !== 5'd0 || nb_data(0) !== 32'h0) begin n_fail++; $display("FAIL async_reset_state: got %0d/%h expected 0/0", bus_nb.written_count, nb_data(0)); end
    @(negedge clk);
    nrst = 1'b1;
    bus_nb.rd_data_ready[0] = 1'b1;
    bus_nb.rd_addr_valid[0] = 1'b1;
    @(negedge clk);
    bus_nb.rd_addr_valid[0] = 1'b0;
    n_checks++; if (bus_nb.rd_data_valid[0] !== 1'b1 || bus_nb.rd_written[0] !== 1'b0) begin n_fail++; $display("FAIL post_reset_read: got %b/%b expected 1/0", bus_nb.rd_data_valid[0], bus_nb.rd_written[0]); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_empty_read();
    test_fill_and_read();
    test_blocking();
    test_same_cycle();
    test_back_pressure();
    test_clr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
